two_hot_mul_sequencer: RTL and testbench

Sequencer and accumulator wrapped around `two_bit_multiplier2`, which only accepts multiplier words with at most two set bits. It accepts an arbitrary 16-bit × N-bit operand pair and splits `b` into "two-hot" chunks, lowest set bits first. It issues each chunk to the multiplier, sums the partial products, and returns the full product through a valid/ready output.

---
 rtl/two_hot_mul_sequencer_if.sv | 33 +++
 rtl/two_hot_mul_sequencer.sv | 106 ++++++++++
 tb/tb_two_hot_mul_sequencer.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/two_hot_mul_sequencer_if.sv
`default_nettype none
// ============================================================================
// two_hot_mul_sequencer_if
// Operand, multiplier-side and product handshake bundle for the sequencer.
// Revision: 1.0
// ============================================================================
interface two_hot_mul_sequencer_if #(
    parameter int N = 4
);
    logic          in_vld;
    logic          in_rdy;
    logic [15:0]   in_a;
    logic [N-1:0]  in_b;
    logic          mul_vld;
    logic [15:0]   mul_a;
    logic [N-1:0]  mul_b;
    logic [31:0]   mul_c;
    logic          mul_result_vld;
    logic          out_vld;
    logic          out_rdy;
    logic [31:0]   out_p;

    modport master (
        output in_vld, in_a, in_b, mul_c, mul_result_vld, out_rdy,
        input  in_rdy, mul_vld, mul_a, mul_b, out_vld, out_p
    );

    modport slave (
        input  in_vld, in_a, in_b, mul_c, mul_result_vld, out_rdy,
        output in_rdy, mul_vld, mul_a, mul_b, out_vld, out_p
    );
endinterface
`default_nettype wire

// File: rtl/two_hot_mul_sequencer.sv
`default_nettype none
// ============================================================================
// two_hot_mul_sequencer
// Splits b into two-hot chunks, feeds them to the external multiplier and sums.
// Revision: 1.0
// ============================================================================
module two_hot_mul_sequencer #(
    parameter int N = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    two_hot_mul_sequencer_if.slave       bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [15:0]   a_q;
    logic [15:0]   a_nx;
    logic [N-1:0]  rem_q;
    logic [N-1:0]  rem_nx;
    logic [N-1:0]  chunk_q;
    logic [N-1:0]  chunk_nx;
    logic [31:0]   acc_q;
    logic [31:0]   acc_nx;

    logic [N-1:0]  low_bit;
    logic [N-1:0]  rem_rest;
    logic [N-1:0]  next_bit;
    logic [N-1:0]  chunk_sel;
    logic [N-1:0]  rem_cleared;

    // x & -x isolates the lowest set bit; applied twice gives the two lowest.
    assign low_bit     = rem_q & (-rem_q);
    assign rem_rest    = rem_q ^ low_bit;
    assign next_bit    = rem_rest & (-rem_rest);
    assign chunk_sel   = low_bit | next_bit;
    assign rem_cleared = rem_q & ~chunk_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            a_q     <= '0;
            rem_q   <= '0;
            chunk_q <= '0;
            acc_q   <= '0;
        end else begin
            state   <= state_nx;
            a_q     <= a_nx;
            rem_q   <= rem_nx;
            chunk_q <= chunk_nx;
            acc_q   <= acc_nx;
        end
    end

    always_comb begin
        state_nx = state;
        a_nx     = a_q;
        rem_nx   = rem_q;
        chunk_nx = chunk_q;
        acc_nx   = acc_q;
        case (state)
            IDLE: begin
                if (bus.in_vld) begin
                    a_nx     = bus.in_a;
                    rem_nx   = bus.in_b;
                    acc_nx   = '0;
                    state_nx = (bus.in_b == '0) ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                chunk_nx = chunk_sel;
                state_nx = WAIT;
            end
            WAIT: begin
                if (bus.mul_result_vld) begin
                    acc_nx   = acc_q + bus.mul_c;
                    rem_nx   = rem_cleared;
                    state_nx = (rem_cleared == '0) ? DONE : ISSUE;
                end
            end
            DONE: begin
                if (bus.out_rdy) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Outputs depend on registered state only, so no input-to-output paths.
    assign bus.in_rdy  = (state == IDLE);
    assign bus.mul_vld = (state == ISSUE);
    assign bus.mul_a   = a_q;
    assign bus.mul_b   = (state == ISSUE) ? chunk_sel : chunk_q;
    assign bus.out_vld = (state == DONE);
    assign bus.out_p   = acc_q;
endmodule
`default_nettype wire

// File: tb/tb_two_hot_mul_sequencer.sv
`default_nettype none
// ============================================================================
// tb_two_hot_mul_sequencer
// Directed and random operations against a product/chunk/latency reference.
// Revision: 1.0
// ============================================================================
module tb_two_hot_mul_sequencer;
    localparam int N = 4;

    logic clk;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    int   viol  = 0;

    two_hot_mul_sequencer_if #(.N(N)) bus ();

    two_hot_mul_sequencer #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Multiplier stand-in: result two cycles after the request, reset with rst.
    logic        s1;
    logic        s2;
    logic [31:0] p1;
    logic [31:0] c_q;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            s1  <= 1'b0;
            s2  <= 1'b0;
            p1  <= '0;
            c_q <= '0;
        end else begin
            if (bus.mul_vld && (s1 || s2)) viol <= viol + 1;
            s1 <= bus.mul_vld;
            s2 <= s1;
            if (bus.mul_vld) p1 <= 32'(bus.mul_a) * 32'(bus.mul_b);
            if (s1) c_q <= p1;
        end
    end

    assign bus.mul_result_vld = s2;
    assign bus.mul_c          = c_q;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input logic [15:0] a, input logic [N-1:0] b,
                          input int hold, input string name);
        int           pos[$];
        logic [N-1:0] chunks[$];
        logic [N-1:0] ch;
        logic [31:0]  exp_p;
        int           k;
        int           idx;
        int           out_cyc;
        int           waited;

        for (int i = 0; i < N; i++) if (b[i]) pos.push_back(i);
        for (int i = 0; i < pos.size(); i += 2) begin
            ch = '0;
            ch[pos[i]] = 1'b1;
            if (i + 1 < pos.size()) ch[pos[i+1]] = 1'b1;
            chunks.push_back(ch);
        end
        k     = chunks.size();
        exp_p = 32'(a) * 32'(b);

        waited = 0;
        while (bus.in_rdy !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check({name, ":ready"}, 32'(bus.in_rdy), 32'd1);

        bus.in_vld = 1'b1;
        bus.in_a   = a;
        bus.in_b   = b;
        @(negedge clk);
        bus.in_vld = 1'b0;
        bus.in_a   = 16'($urandom);
        bus.in_b   = N'($urandom);

        idx     = 0;
        out_cyc = -1;
        for (int cyc = 1; cyc <= 3 * N + 6; cyc++) begin
            if (bus.out_vld === 1'b1) begin
                out_cyc = cyc;
                break;
            end
            check({name, ":busy_in_rdy"}, 32'(bus.in_rdy), 32'd0);
            if (bus.mul_vld === 1'b1) begin
                check({name, ":issue_cycle"}, 32'(cyc), 32'(3 * idx + 1));
                check({name, ":mul_a"}, 32'(bus.mul_a), 32'(a));
                if (idx < k) check({name, ":mul_b"}, 32'(bus.mul_b), 32'(chunks[idx]));
                else         check({name, ":extra_chunk"}, 32'(idx), 32'(k));
                idx++;
            end
            @(negedge clk);
        end
        check({name, ":chunk_count"}, 32'(idx), 32'(k));
        check({name, ":out_cycle"}, 32'(out_cyc), (k == 0) ? 32'd1 : 32'(3 * k + 1));
        check({name, ":product"}, bus.out_p, exp_p);

        for (int h = 0; h < hold; h++) begin
            bus.in_vld = 1'b1;
            bus.in_a   = 16'($urandom);
            bus.in_b   = N'($urandom);
            @(negedge clk);
            check({name, ":hold_out_p"}, bus.out_p, exp_p);
            check({name, ":hold_out_vld"}, 32'(bus.out_vld), 32'd1);
            check({name, ":hold_in_rdy"}, 32'(bus.in_rdy), 32'd0);
        end
        bus.in_vld  = 1'b0;
        bus.out_rdy = 1'b1;
        @(negedge clk);
        bus.out_rdy = 1'b0;
        check({name, ":idle_in_rdy"}, 32'(bus.in_rdy), 32'd1);
        check({name, ":idle_out_vld"}, 32'(bus.out_vld), 32'd0);
    endtask

    initial begin
        rst         = 1'b1;
        bus.in_vld  = 1'b0;
        bus.in_a    = '0;
        bus.in_b    = '0;
        bus.out_rdy = 1'b0;
        repeat (3) @(negedge clk);
        check("rst:mul_vld", 32'(bus.mul_vld), 32'd0);
        check("rst:mul_a", 32'(bus.mul_a), 32'd0);
        check("rst:mul_b", 32'(bus.mul_b), 32'd0);
        check("rst:out_vld", 32'(bus.out_vld), 32'd0);
        check("rst:out_p", bus.out_p, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rst:in_rdy", 32'(bus.in_rdy), 32'd1);

        run_op(16'd3, 4'b0101, 0, "single");
        run_op(16'hFFFF, 4'b1111, 0, "two_chunks");
        run_op(16'd1234, 4'b0000, 0, "zero_b");
        run_op(16'd7, 4'b1000, 0, "lone_high");
        run_op(16'd9, 4'b1011, 5, "backpressure");
        run_op(16'd5, 4'b0011, 0, "after_bp");

        // Abort during the second chunk's WAIT (cycle 5).
        bus.in_vld = 1'b1;
        bus.in_a   = 16'h1357;
        bus.in_b   = 4'b1011;
        @(negedge clk);
        bus.in_vld = 1'b0;
        repeat (4) @(negedge clk);
        check("abort:pre_out_vld", 32'(bus.out_vld), 32'd0);
        rst = 1'b1;
        #1;
        check("abort:out_vld", 32'(bus.out_vld), 32'd0);
        check("abort:mul_vld", 32'(bus.mul_vld), 32'd0);
        check("abort:out_p", bus.out_p, 32'd0);
        check("abort:mul_a", 32'(bus.mul_a), 32'd0);
        check("abort:mul_b", 32'(bus.mul_b), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort:in_rdy", 32'(bus.in_rdy), 32'd1);
        @(negedge clk);
        run_op(16'd2, 4'b0110, 0, "post_abort");

        for (int r = 0; r < 40; r++) begin
            run_op(16'($urandom), N'($urandom), int'($urandom_range(0, 2)), "random");
        end

        check("mul_busy_violations", 32'(viol), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
